// File: rtl/reg_file.sv
// Multi-port register file: two registered read ports with same-edge bypass,
// one bit-masked write port, optional zero register and a sequenced clear sweep.
module reg_file #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] wmask,
    input  logic [AW-1:0]    ra_addr,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    input  logic             clr,
    output logic             busy,
    output logic             wdrop
);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] ra_q, rb_q;
    logic wdrop_q, wdrop_d;
    logic sweep;

    assign sweep = (state_q == SWEEP);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next-state contents feed both storage and the read ports (full bypass).
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (sweep && ptr_q == AW'(i)) begin
                mem_d[i] = '0;
            end else if (!sweep && we && waddr == AW'(i)) begin
                mem_d[i] = (mem_q[i] & ~wmask) | (wdata & wmask);
            end
        end
        if (ZERO_REG != 0) begin
            mem_d[0] = '0;
        end
    end

    always_comb begin
        wdrop_d = sweep && we;
        if (ZERO_REG != 0 && waddr == '0) begin
            wdrop_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            wdrop_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ra_q    <= mem_d[ra_addr];
            rb_q    <= mem_d[rb_addr];
            wdrop_q <= wdrop_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign ra_data = ra_q;
    assign rb_data = rb_q;
    assign busy    = sweep;
    assign wdrop   = wdrop_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: vector table for write/read/bypass/mask/zero-reg,
// hand sequences for the clear sweep and reset mid-sweep.
module tb_reg_file;

    logic        CLK = 1'b0;
    logic        RES = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  waddr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] wmask = '0;
    logic [3:0]  ra_addr = '0;
    logic [3:0]  rb_addr = '0;
    logic        clr = 1'b0;
    logic [15:0] ra_data, rb_data, ra1, rb1;
    logic        busy, wdrop, busy1, wdrop1;

    int vectors = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    reg_file #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1)) dut (
        .CLK(CLK), .RES(RES), .we(we), .waddr(waddr), .wdata(wdata),
        .wmask(wmask), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_data), .rb_data(rb_data), .clr(clr),
        .busy(busy), .wdrop(wdrop)
    );

    reg_file #(.WIDTH(16), .DEPTH(16), .ZERO_REG(0)) dut1 (
        .CLK(CLK), .RES(RES), .we(we), .waddr(waddr), .wdata(wdata),
        .wmask(wmask), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra1), .rb_data(rb1), .clr(clr),
        .busy(busy1), .wdrop(wdrop1)
    );

    typedef struct {
        logic        we;
        logic [3:0]  waddr;
        logic [15:0] wdata;
        logic [15:0] wmask;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [15:0] exp_ra;
        logic [15:0] exp_rb;
        logic [15:0] exp_ra1;
    } vec_t;

    vec_t tbl [10];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    int busy_cnt;
    int drop_cnt;
    int j;

    initial begin
        tbl[0] = '{1, 5, 16'hBEEF, 16'hFFFF, 0, 0, 16'h0000, 16'h0000, 16'h0000};
        tbl[1] = '{0, 0, 16'h0000, 16'h0000, 5, 0, 16'hBEEF, 16'h0000, 16'hBEEF};
        tbl[2] = '{1, 3, 16'h1234, 16'hFFFF, 3, 3, 16'h1234, 16'h1234, 16'h1234};
        tbl[3] = '{1, 7, 16'hFFFF, 16'hFFFF, 7, 5, 16'hFFFF, 16'hBEEF, 16'hFFFF};
        tbl[4] = '{1, 7, 16'h0000, 16'h00F0, 7, 3, 16'hFF0F, 16'h1234, 16'hFF0F};
        tbl[5] = '{1, 0, 16'hAAAA, 16'hFFFF, 0, 7, 16'h0000, 16'hFF0F, 16'hAAAA};
        tbl[6] = '{1, 7, 16'h1234, 16'h0000, 7, 0, 16'hFF0F, 16'h0000, 16'hFF0F};
        tbl[7] = '{1, 9, 16'hABCD, 16'hFF00, 9, 0, 16'hAB00, 16'h0000, 16'hAB00};
        tbl[8] = '{0, 0, 16'h0000, 16'h0000, 9, 7, 16'hAB00, 16'hFF0F, 16'hAB00};
        tbl[9] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hAAAA};

        // Reset state
        we = 1'b1; waddr = 4'd5; wdata = 16'h5A5A; wmask = 16'hFFFF;
        ra_addr = 4'd5; rb_addr = 4'd5; clr = 1'b1;
        step();
        step();
        chk("reset_ra", ra_data, 16'h0);
        chk("reset_rb", rb_data, 16'h0);
        chk("reset_busy", {15'h0, busy}, 16'h0);
        chk("reset_wdrop", {15'h0, wdrop}, 16'h0);
        chk("reset_ra1", ra1, 16'h0);
        we = 1'b0; clr = 1'b0; ra_addr = '0; rb_addr = '0;
        #2 RES = 1'b1;

        // Table: write/read/bypass/mask/zero register
        for (int i = 0; i < 10; i++) begin
            we = tbl[i].we; waddr = tbl[i].waddr;
            wdata = tbl[i].wdata; wmask = tbl[i].wmask;
            ra_addr = tbl[i].ra; rb_addr = tbl[i].rb;
            step();
            chk($sformatf("vec%0d_ra", i), ra_data, tbl[i].exp_ra);
            chk($sformatf("vec%0d_rb", i), rb_data, tbl[i].exp_rb);
            chk($sformatf("vec%0d_ra1", i), ra1, tbl[i].exp_ra1);
            chk($sformatf("vec%0d_wdrop", i), {15'h0, wdrop}, 16'h0);
        end

        // Fill every register with a nonzero value
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; waddr = 4'(i); wdata = 16'h1000 + 16'(i);
            wmask = 16'hFFFF;
            step();
        end
        we = 1'b0;

        // Sweep with dropped write and ignored second clr
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("sweep_start_busy", {15'h0, busy}, 16'h1);
        busy_cnt = 1;
        drop_cnt = 0;
        j = 1;
        while (busy && j < 40) begin
            we = (j == 4); waddr = 4'd2; wdata = 16'hFFFF; wmask = 16'hFFFF;
            clr = (j == 6);
            ra_addr = 4'd10; rb_addr = 4'd3;
            step();
            if (j == 4) begin
                chk("sweep_old_r10", ra_data, 16'h100A);
                chk("sweep_bypass_r3", rb_data, 16'h0000);
            end
            if (busy) busy_cnt++;
            if (wdrop) drop_cnt++;
            j++;
        end
        we = 1'b0; clr = 1'b0;
        chk("sweep_busy_cycles", 16'(busy_cnt), 16'd16);
        chk("sweep_wdrop_pulses", 16'(drop_cnt), 16'd1);

        // First write after busy falls lands on a cleared r2
        we = 1'b1; waddr = 4'd2; wdata = 16'h5555; wmask = 16'h00FF;
        ra_addr = 4'd2; rb_addr = 4'd2;
        step();
        we = 1'b0;
        chk("post_sweep_write", ra_data, 16'h0055);
        chk("post_sweep_busy", {15'h0, busy}, 16'h0);
        chk("post_sweep_wdrop", {15'h0, wdrop}, 16'h0);
        for (int i = 0; i < 8; i++) begin
            ra_addr = 4'(2 * i); rb_addr = 4'(2 * i + 1);
            step();
            chk($sformatf("clear_r%0d", 2 * i), ra_data,
                (i == 1) ? 16'h0055 : 16'h0000);
            chk($sformatf("clear_r%0d", 2 * i + 1), rb_data, 16'h0000);
        end

        // Reset mid-sweep
        we = 1'b1; waddr = 4'd12; wdata = 16'h4321; wmask = 16'hFFFF;
        step();
        we = 1'b0; clr = 1'b1;
        ra_addr = 4'd12; rb_addr = 4'd12;
        step();
        clr = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("midsweep_busy", {15'h0, busy}, 16'h1);
        chk("midsweep_r12_old", ra_data, 16'h4321);
        #2 RES = 1'b0;
        #1;
        chk("async_busy", {15'h0, busy}, 16'h0);
        chk("async_ra", ra_data, 16'h0);
        #2 RES = 1'b1;
        step();
        chk("after_reset_r12", ra_data, 16'h0000);
        chk("after_reset_busy", {15'h0, busy}, 16'h0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        busy_cnt = busy ? 1 : 0;
        j = 0;
        while (busy && j < 40) begin
            step();
            if (busy) busy_cnt++;
            j++;
        end
        chk("resweep_busy_cycles", 16'(busy_cnt), 16'd16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Parametrised multi-port register file for the CPU datapath. It generalises the single 16-bit reset register into DEPTH registers of WIDTH bits, with:
- two registered read ports and one bit-masked write port;
- same-edge write-to-read bypass;
- optional hardwired zero register;
- a sequenced clear engine that zeroes the whole file one register per cycle.

It sits between instruction decode (addresses) and the ALU (operands and results).

## Interface
- WIDTH, 16: data width of each register, ≥1.
- DEPTH, 16: number of registers, power of two, ≥2; AW = log2(DEPTH).
- ZERO_REG, 1: 1 means register 0 always reads 0 and ignores writes; 0 means register 0 is ordinary.
- CLK  in  1  rising-edge clock, single clock domain.
- RES  in  1  asynchronous, active-low reset.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- wmask  in  WIDTH  per-bit write mask (1 = bit is written).
- ra_addr, rb_addr  in  AW  read addresses for ports A and B.
- ra_data, rb_data  out  WIDTH  registered read data.
- clr  in  1  clear request (single-cycle pulse or level; sampled only in IDLE).
- busy  out  1  clear sweep in progress.
- wdrop  out  1  one-cycle pulse: a write was discarded.

## Operation
- Storage
  - DEPTH×WIDTH flops.
- Write, in state IDLE with we=1
  - reg[waddr] ← (reg[waddr] & ~wmask) | (wdata & wmask) at the rising edge.
  - wmask=0 leaves the register unchanged and is not a drop.
  - With ZERO_REG=1, writes to address 0 are silently ignored; wdrop does not pulse.
- Reads
  - Each edge: ra_data ← next-state value of reg[ra_addr], i.e. the value the register holds after this edge's write or clear.
  - This gives full same-edge bypass, including partial masks.
  - rb_data behaves identically for port B.
  - With ZERO_REG=1, address 0 always yields 0.
- Clear FSM, states IDLE and SWEEP
  - IDLE → SWEEP when clr=1; internal pointer ptr ← 0.
  - SWEEP: each edge, reg[ptr] ← 0 and ptr ← ptr+1.
  - The edge that clears ptr=DEPTH-1 returns the FSM to IDLE; ptr wraps to 0.
  - busy=1 exactly while in SWEEP (registered output).
  - clr while in SWEEP is ignored; no restart and no extension.
- Writes during SWEEP
  - we=1 in SWEEP is discarded entirely; wdrop=1 on the following cycle.
  - Exception: ZERO_REG=1 and waddr=0 is silently ignored, as in IDLE.
- Reads during SWEEP
  - Return current contents.
  - The register being cleared at an edge reads 0 through the bypass.
  - Not-yet-cleared registers return their old values.
- Reset
  - RES=0 asynchronously forces all registers to 0, ra_data=0, rb_data=0, busy=0, wdrop=0, state IDLE, ptr=0.
  - Reset asserted mid-sweep aborts the sweep.
  - Release is effective from the first rising edge with RES=1.

## Timing
- Write latency: 1 edge. Data presented at edge k is stored at edge k.
- Read latency: 1 edge. An address presented before edge k gives data valid after edge k.
- A write and a read of the same address at edge k: read data after k equals the merged written value.
- clr sampled at edge k (IDLE):
  - busy=1 after k.
  - Registers 0..DEPTH-1 are cleared at edges k+1..k+DEPTH.
  - busy=0 after edge k+DEPTH.
  - A write is accepted again at edge k+DEPTH+1.
- clr and we together at an IDLE edge: the write is performed at that edge, then the sweep starts next edge and eventually clears it.
- wdrop rises 1 edge after the discarded write and lasts exactly 1 cycle per discarded write.
- No combinational path from any input to any output.

## Test plan
- Reset/basic, WIDTH=16, DEPTH=16:
  - Stimulus: hold RES=0, release; write 0xBEEF to r5 (mask 0xFFFF); next cycle read r5 on port A.
  - Required: all outputs 0 during reset; ra_data=0xBEEF one edge after the read address.
- Bypass:
  - Stimulus: write r3=0x1234 with ra_addr=rb_addr=3 at the same edge.
  - Required: both ports show 0x1234 after that edge, not the old value 0.
- Mask:
  - Stimulus: r7=0xFFFF; write wdata=0x0000, wmask=0x00F0.
  - Required: r7 reads 0xFF0F.
- Zero register, ZERO_REG=1:
  - Stimulus: write 0xAAAA to r0.
  - Required: r0 reads 0x0000; wdrop stays 0.
  - With ZERO_REG=0, the same write makes r0 read 0xAAAA.
- Sweep:
  - Stimulus: fill all 16 registers with nonzero values; pulse clr; write r2 during the sweep; pulse clr again mid-sweep.
  - Required: busy high exactly 16 cycles; one wdrop pulse; r2 ends at 0; all registers 0 afterwards; the second clr has no effect.
  - The first write after busy falls succeeds.
- Reset mid-sweep:
  - Stimulus: assert RES=0 at sweep cycle 5, asynchronously between edges.
  - Required: busy drops immediately; all registers 0; after release a new clr performs a full 16-cycle sweep.
